// File: rtl/sdf_issue_scheduler.sv
// Arbitrates new and feedback rays into the fixed-latency SDF pipeline and tags each point through it.
// Optional SDF_SCHED_PERF_EN adds saturating issue/bubble/starve counters.
module sdf_issue_scheduler #(
  parameter int          TAG_W        = 8,
  parameter int          SDF_LAT      = 12,
  parameter int          MAX_INFLIGHT = 13,
  parameter int          STARVE_LIMIT = 4,
  parameter logic [3:0]  POW_RESET    = 4'd2
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              new_valid,
  output logic                              new_ready,
  input  logic [26:0]                       new_x,
  input  logic [26:0]                       new_y,
  input  logic [26:0]                       new_z,
  input  logic [TAG_W-1:0]                  new_tag,
  input  logic                              fb_valid,
  output logic                              fb_ready,
  input  logic [26:0]                       fb_x,
  input  logic [26:0]                       fb_y,
  input  logic [26:0]                       fb_z,
  input  logic [TAG_W-1:0]                  fb_tag,
  output logic [26:0]                       sdf_x,
  output logic [26:0]                       sdf_y,
  output logic [26:0]                       sdf_z,
  output logic [3:0]                        sdf_pow,
  input  logic [26:0]                       sdf_dist,
  output logic                              res_valid,
  output logic [TAG_W-1:0]                  res_tag,
  output logic [26:0]                       res_x,
  output logic [26:0]                       res_y,
  output logic [26:0]                       res_z,
  output logic [26:0]                       res_dist,
  input  logic                              cfg_valid,
  input  logic [3:0]                        cfg_pow,
  output logic                              cfg_ready,
  output logic                              cfg_done,
  output logic [$clog2(MAX_INFLIGHT+1)-1:0] inflight
`ifdef SDF_SCHED_PERF_EN
  ,
  output logic [31:0]                       perf_issue,
  output logic [31:0]                       perf_bubble,
  output logic [31:0]                       perf_starve
`endif
);

  localparam int CNT_W = $clog2(MAX_INFLIGHT+1);
  localparam int STV_W = $clog2(STARVE_LIMIT+1);
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_INFLIGHT);
  localparam logic [STV_W-1:0] STV_MAX = STV_W'(STARVE_LIMIT);

  typedef enum logic [1:0] {RUN, DRAIN, APPLY} state_t;

  typedef struct packed {
    logic [TAG_W-1:0] tag;
    logic [26:0]      x;
    logic [26:0]      y;
    logic [26:0]      z;
  } pt_t;

  state_t           r_state, w_state_nxt;
  logic [CNT_W-1:0] r_inflight;
  logic [STV_W-1:0] r_starve;
  logic [3:0]       r_pending;
  logic [3:0]       r_sdf_pow;
  logic             r_cfg_done;
  logic [26:0]      r_sdf_x, r_sdf_y, r_sdf_z;
  logic [SDF_LAT:0] r_pipe_vld;
  pt_t              r_pipe [0:SDF_LAT];

  logic w_issue_ok, w_force_new, w_grant, w_cfg_acc;
  pt_t  w_sel;

  assign w_issue_ok  = (r_state == RUN) && (r_inflight < MAX_CNT);
  // Starvation override only bites while a new ray is actually waiting.
  assign w_force_new = (r_starve == STV_MAX) && new_valid;
  assign fb_ready    = w_issue_ok && fb_valid && !w_force_new;
  assign new_ready   = w_issue_ok && new_valid && (w_force_new || !fb_valid);
  assign w_grant     = fb_ready || new_ready;
  assign w_sel       = fb_ready ? pt_t'{fb_tag, fb_x, fb_y, fb_z}
                                : pt_t'{new_tag, new_x, new_y, new_z};
  assign cfg_ready   = (r_state == RUN);
  assign w_cfg_acc   = cfg_valid && cfg_ready;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      RUN:     if (w_cfg_acc) w_state_nxt = DRAIN;
      DRAIN:   if (r_inflight == '0) w_state_nxt = APPLY;
      APPLY:   w_state_nxt = RUN;
      default: w_state_nxt = RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= RUN;
      r_inflight <= '0;
      r_starve   <= '0;
      r_pending  <= POW_RESET;
      r_sdf_pow  <= POW_RESET;
      r_cfg_done <= 1'b0;
      r_sdf_x    <= '0;
      r_sdf_y    <= '0;
      r_sdf_z    <= '0;
      r_pipe_vld <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_cfg_done <= (r_state == APPLY);
      r_pipe_vld <= {r_pipe_vld[SDF_LAT-1:0], w_grant};
      if (w_cfg_acc) r_pending <= cfg_pow;
      if (r_state == APPLY) r_sdf_pow <= r_pending;
      if (w_grant) begin
        r_sdf_x <= w_sel.x;
        r_sdf_y <= w_sel.y;
        r_sdf_z <= w_sel.z;
      end
      if (w_grant && !res_valid)      r_inflight <= r_inflight + CNT_W'(1);
      else if (!w_grant && res_valid) r_inflight <= r_inflight - CNT_W'(1);
      if (fb_ready && new_valid)       r_starve <= r_starve + STV_W'(1);
      else if (new_ready || !new_valid) r_starve <= '0;
    end
  end

  // Payload needs no reset: the valid bits alone qualify every stage.
  always_ff @(posedge clk) begin
    r_pipe[0] <= w_sel;
    for (int i = 1; i <= SDF_LAT; i++) r_pipe[i] <= r_pipe[i-1];
  end

  assign sdf_x     = r_sdf_x;
  assign sdf_y     = r_sdf_y;
  assign sdf_z     = r_sdf_z;
  assign sdf_pow   = r_sdf_pow;
  assign cfg_done  = r_cfg_done;
  assign inflight  = r_inflight;
  assign res_valid = r_pipe_vld[SDF_LAT];
  assign res_tag   = r_pipe[SDF_LAT].tag;
  assign res_x     = r_pipe[SDF_LAT].x;
  assign res_y     = r_pipe[SDF_LAT].y;
  assign res_z     = r_pipe[SDF_LAT].z;
  assign res_dist  = sdf_dist;

`ifdef SDF_SCHED_PERF_EN
  logic [31:0] r_perf_issue, r_perf_bubble, r_perf_starve;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_perf_issue  <= '0;
      r_perf_bubble <= '0;
      r_perf_starve <= '0;
    end else begin
      if (w_grant && r_perf_issue != '1) r_perf_issue <= r_perf_issue + 32'd1;
      if ((r_state == RUN) && !w_grant && r_perf_bubble != '1)
        r_perf_bubble <= r_perf_bubble + 32'd1;
      if (new_ready && w_force_new && fb_valid && r_perf_starve != '1)
        r_perf_starve <= r_perf_starve + 32'd1;
    end
  end

  assign perf_issue  = r_perf_issue;
  assign perf_bubble = r_perf_bubble;
  assign perf_starve = r_perf_starve;
`endif

endmodule

// File: tb/tb_sdf_issue_scheduler.sv
// Directed bench for sdf_issue_scheduler: default instance plus a MAX_INFLIGHT=3 instance on shared inputs.
module tb_sdf_issue_scheduler;

  logic        clk, rst_n;
  logic        new_valid, fb_valid, cfg_valid;
  logic [26:0] new_x, new_y, new_z, fb_x, fb_y, fb_z, sdf_dist;
  logic [7:0]  new_tag, fb_tag;
  logic [3:0]  cfg_pow;

  logic        new_ready, fb_ready, res_valid, cfg_ready, cfg_done;
  logic [26:0] sdf_x, sdf_y, sdf_z, res_x, res_y, res_z, res_dist;
  logic [3:0]  sdf_pow;
  logic [7:0]  res_tag;
  logic [3:0]  inflight;

  logic        d3_new_ready, d3_fb_ready, d3_res_valid, d3_cfg_ready, d3_cfg_done;
  logic [26:0] d3_sdf_x, d3_sdf_y, d3_sdf_z, d3_res_x, d3_res_y, d3_res_z, d3_res_dist;
  logic [3:0]  d3_sdf_pow;
  logic [7:0]  d3_res_tag;
  logic [1:0]  d3_inflight;

`ifdef SDF_SCHED_PERF_EN
  logic [31:0] p_issue, p_bubble, p_starve, q_issue, q_bubble, q_starve;
`endif

  int n_checks = 0;
  int n_errs   = 0;

  sdf_issue_scheduler dut (
    .clk(clk), .rst_n(rst_n),
    .new_valid(new_valid), .new_ready(new_ready), .new_x(new_x), .new_y(new_y), .new_z(new_z), .new_tag(new_tag),
    .fb_valid(fb_valid), .fb_ready(fb_ready), .fb_x(fb_x), .fb_y(fb_y), .fb_z(fb_z), .fb_tag(fb_tag),
    .sdf_x(sdf_x), .sdf_y(sdf_y), .sdf_z(sdf_z), .sdf_pow(sdf_pow), .sdf_dist(sdf_dist),
    .res_valid(res_valid), .res_tag(res_tag), .res_x(res_x), .res_y(res_y), .res_z(res_z), .res_dist(res_dist),
    .cfg_valid(cfg_valid), .cfg_pow(cfg_pow), .cfg_ready(cfg_ready), .cfg_done(cfg_done), .inflight(inflight)
`ifdef SDF_SCHED_PERF_EN
    , .perf_issue(p_issue), .perf_bubble(p_bubble), .perf_starve(p_starve)
`endif
  );

  sdf_issue_scheduler #(.MAX_INFLIGHT(3)) dut3 (
    .clk(clk), .rst_n(rst_n),
    .new_valid(new_valid), .new_ready(d3_new_ready), .new_x(new_x), .new_y(new_y), .new_z(new_z), .new_tag(new_tag),
    .fb_valid(fb_valid), .fb_ready(d3_fb_ready), .fb_x(fb_x), .fb_y(fb_y), .fb_z(fb_z), .fb_tag(fb_tag),
    .sdf_x(d3_sdf_x), .sdf_y(d3_sdf_y), .sdf_z(d3_sdf_z), .sdf_pow(d3_sdf_pow), .sdf_dist(sdf_dist),
    .res_valid(d3_res_valid), .res_tag(d3_res_tag), .res_x(d3_res_x), .res_y(d3_res_y), .res_z(d3_res_z),
    .res_dist(d3_res_dist), .cfg_valid(cfg_valid), .cfg_pow(cfg_pow), .cfg_ready(d3_cfg_ready),
    .cfg_done(d3_cfg_done), .inflight(d3_inflight)
`ifdef SDF_SCHED_PERF_EN
    , .perf_issue(q_issue), .perf_bubble(q_bubble), .perf_starve(q_starve)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    new_valid = 0; fb_valid = 0; cfg_valid = 0; cfg_pow = 0;
    new_x = 0; new_y = 0; new_z = 0; new_tag = 0;
    fb_x = 0; fb_y = 0; fb_z = 0; fb_tag = 0;
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
  endtask

  initial begin
    logic [7:0] exp_q [$];
    int fi, ni, k, lat, nres;
    bit exp_new, exp_g;

    sdf_dist = 27'h0ABCDE;
    do_reset();

    // reset state
    check("rst_res_valid", res_valid, 0);
    check("rst_inflight", inflight, 0);
    check("rst_sdf_pow", sdf_pow, 2);
    check("rst_sdf_x", sdf_x, 0);
    check("rst_cfg_ready", cfg_ready, 1);
    check("rst_cfg_done", cfg_done, 0);

    // single new ray: result exactly 13 cycles after grant
    @(posedge clk); #1;
    new_valid = 1; new_tag = 8'h05;
    new_x = 27'h1fc0000; new_y = 27'h2000000; new_z = 27'h2020000;
    @(negedge clk);
    check("single_new_ready", new_ready, 1);
    check("single_fb_ready", fb_ready, 0);
    @(posedge clk); #1;
    new_valid = 0;
    lat = 0; nres = 0;
    for (int n = 1; n <= 20; n++) begin
      if (n > 1) @(posedge clk);
      @(negedge clk);
      if (n == 1) begin
        check("single_sdf_x", sdf_x, 27'h1fc0000);
        check("single_inflight", inflight, 1);
      end
      if (res_valid) begin
        nres++;
        if (lat == 0) begin
          lat = n;
          check("single_res_tag", res_tag, 8'h05);
          check("single_res_x", res_x, 27'h1fc0000);
          check("single_res_y", res_y, 27'h2000000);
          check("single_res_z", res_z, 27'h2020000);
          check("single_res_dist", res_dist, 27'h0ABCDE);
        end
      end
    end
    check("single_latency", lat, 13);
    check("single_res_count", nres, 1);
    check("single_inflight_end", inflight, 0);

    // starvation: 4 fb grants then 1 forced new grant, order kept at result
    do_reset();
    fi = 0; ni = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      new_valid = 1; fb_valid = 1;
      new_tag = 8'(ni); fb_tag = 8'h80 | 8'(fi);
      @(negedge clk);
      exp_new = ((i % 5) == 4);
      check($sformatf("starve_new_ready_%0d", i), new_ready, exp_new);
      check($sformatf("starve_fb_ready_%0d", i), fb_ready, !exp_new);
      if (exp_new) begin exp_q.push_back(8'(ni)); ni++; end
      else begin exp_q.push_back(8'h80 | 8'(fi)); fi++; end
    end
    @(posedge clk); #1;
    new_valid = 0; fb_valid = 0;
    k = 0;
    for (int n = 0; n < 40; n++) begin
      if (n > 0) @(posedge clk);
      @(negedge clk);
      if (res_valid) begin
        if (k < exp_q.size()) check($sformatf("starve_order_%0d", k), res_tag, exp_q[k]);
        k++;
      end
    end
    check("starve_res_count", k, 10);

    // inflight cap of 3 on the second instance
    do_reset();
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #1;
      new_valid = 1; fb_valid = 1;
      @(negedge clk);
      exp_g = (c <= 2) || (c >= 14 && c <= 16);
      check($sformatf("cap_grant_%0d", c), d3_new_ready | d3_fb_ready, exp_g);
      if (c == 13) check("cap_first_res", d3_res_valid, 1);
      if (c == 14) check("cap_inflight_14", d3_inflight, 2);
      if (c == 15) check("cap_inflight_simul", d3_inflight, 2);
      if (c == 17) check("cap_inflight_17", d3_inflight, 3);
    end

    // config change: drain, apply, done pulse
    do_reset();
    nres = 0;
    for (int c = 0; c <= 22; c++) begin
      @(posedge clk); #1;
      new_valid = 1; new_tag = 8'(c); new_x = 27'(c + 1);
      cfg_valid = (c >= 5 && c <= 19);
      cfg_pow = (c == 5) ? 4'd3 : 4'd7;
      @(negedge clk);
      if (res_valid) nres++;
      check($sformatf("cfg_new_ready_%0d", c), new_ready, (c <= 5) || (c >= 21));
      if (c == 5)  begin check("cfg_ready_run", cfg_ready, 1); check("cfg_inflight5", inflight, 5); end
      if (c == 6)  begin check("cfg_ready_drain", cfg_ready, 0); check("cfg_inflight6", inflight, 6); end
      if (c == 19) check("cfg_inflight19", inflight, 0);
      if (c == 20) begin check("cfg_pow_20", sdf_pow, 2); check("cfg_done_20", cfg_done, 0); end
      if (c == 21) begin check("cfg_pow_21", sdf_pow, 3); check("cfg_done_21", cfg_done, 1); end
      if (c == 22) begin check("cfg_pow_22", sdf_pow, 3); check("cfg_done_22", cfg_done, 0); end
    end
    check("cfg_drain_results", nres, 6);

    // reset mid-flight discards everything
    for (int c = 0; c < 6; c++) begin
      @(posedge clk); #1;
      new_valid = 1; new_x = 27'h0100000 | 27'(c);
    end
    @(posedge clk); #1;
    new_valid = 0;
    @(negedge clk);
    check("mid_sdf_x", sdf_x, 27'h0100005);
    check("mid_inflight", inflight, 8);
    rst_n = 1'b0;
    #1;
    check("mid_rst_sdf_x", sdf_x, 0);
    check("mid_rst_inflight", inflight, 0);
    check("mid_rst_pow", sdf_pow, 2);
    check("mid_rst_res_valid", res_valid, 0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    nres = 0;
    for (int n = 0; n < 30; n++) begin
      @(negedge clk);
      if (res_valid) nres++;
    end
    check("mid_no_stale_res", nres, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errs);
    $finish;
  end

endmodule
